fp_norm_round_pack: RTL and testbench
=====================================

// Module: fp_norm_round_pack
// PURPOSE
// Back end of the FP adder datapath: receives the unnormalized sum (sign, exponent, wide mantissa)
// and produces a packed IEEE-754 word. Normalizes right on carry-out or left one bit per cycle after
// cancellation, rounds to nearest-even, and flags overflow/underflow/inexact. Valid/ready on both sides.
// PARAMETERS
// EXP_W  8   exponent width
// MAN_W  23  stored fraction width; in_mant = {C, H, F[MAN_W-1:0], G, R, S} = MAN_W+5 bits
// PORTS
// CLK          in   1            clock, rising edge
// RST          in   1            asynchronous, active-low reset
// in_valid     in   1            upstream sum valid
// in_ready     out  1            block idle, can accept
// in_sign      in   1            result sign from adder sign logic
// in_exp       in   EXP_W        biased exponent of larger operand
// in_mant      in   MAN_W+5      {carry, hidden, fraction, guard, round, sticky}
// out_valid    out  1            packed result valid
// out_ready    in   1            downstream accepts
// out_data     out  1+EXP_W+MAN_W {sign, exp, frac}
// out_ovf      out  1            result overflowed to infinity
// out_unf      out  1            result flushed to signed zero
// out_inexact  out  1            any of G/R/S nonzero at rounding
// BEHAVIOUR
// - Reset: state IDLE, in_ready=1, out_valid=0, out_data=0, all flags 0; internal regs cleared.
// - Reset mid-operation aborts the in-flight result; nothing is emitted; in_ready=1 after RST release.
// - FSM IDLE->CHECK->{SHIFT}->ROUND->DONE->IDLE. in_ready=1 only in IDLE.
// - IDLE: in_valid&in_ready captures all inputs -> CHECK.
// - CHECK (priority order):
//   in_exp all-ones: pass through {sign, all-ones, F}, no rounding, flags 0 -> DONE.
//   in_mant==0: out {sign,0,0}, flags 0 -> DONE.
//   in_exp==0 (mant!=0): flush to {sign,0,0}, out_unf=1 -> DONE.
//   C=1: shift right 1, old S|R into S, exp+1; exp+1==all-ones -> {sign,all-ones,0}, out_ovf=1 -> DONE;
//     else -> ROUND.
//   H=1 -> ROUND.  else -> SHIFT.
// - SHIFT: one bit/cycle: mant<<1 (S holds, 0 shifts into S), exp-1. H=1 after shift -> ROUND.
//   exp==1 with H=0 before shift -> flush to signed zero, out_unf=1 -> DONE.
// - ROUND (RNE): inc = G & (R | S | F[0]); inexact = G|R|S.
//   {H,F}+inc overflows to 2.0 -> F=0, exp+1; exp becomes all-ones -> {sign,all-ones,0}, out_ovf=1.
//   -> DONE.
// - DONE: out_valid=1; out_data/flags held stable until out_ready; out_valid&out_ready -> IDLE.
//   No bypass: next input accepted the cycle after the handshake.
// - Latency: accept at edge k; out_valid at k+3 for no-shift paths, k+3+N for N left shifts.
//   Special, zero, flush and overflow-in-CHECK paths: out_valid at k+2.
// - Max N = MAN_W+1; counter/exp arithmetic done in EXP_W+1 bits; no wrap below exponent 1.
// STRUCTURE
// - Shared include fp_defs.vh: EXP_W/MAN_W defaults, EXP_MAX, state encodings, mantissa field
//   index constants (C, H, G, R, S).
// - One sub-module rne_round (combinational): {H,F,G,R,S} -> {rounded H,F}, carry_out, inexact.
//   Top holds FSM, exp/mant regs, output regs.
// TESTING
// - Carry-out: sign0 exp0x7F C=1 H=1 F=0 GRS=000 -> 0x40400000, flags 0, out_valid 3 cycles after accept.
// - Cancellation: exp0x85 C=0 H=0 F=0x000001 GRS=000 -> 23 SHIFT cycles -> 0x37000000,
//   out_valid at k+26.
// - RNE: exp0x7F H=1 F=0x000001 GRS=100 -> 0x3F800002 inexact=1;
//   F=0x000002 GRS=100 -> 0x3F800002 inexact=1.
// - Round overflow: exp0xFE H=1 F=0x7FFFFF GRS=110 -> 0x7F800000, out_ovf=1, out_inexact=1.
// - Zero + backpressure: sign0 in_mant=0 -> 0x00000000; out_ready low 5 cycles -> out_valid/out_data
//   stable, in_ready=0; handshake -> IDLE.
// - Reset mid-SHIFT (case 2, RST low at k+10) -> out_valid=0, out_data=0, in_ready=1 after release,
//   no output emitted.

Source files
------------

// File: rtl/fp_norm_round_pack_pkg.sv
// Shared definitions for the FP adder back end: default widths, mantissa field
// positions inside {C, H, F, G, R, S} and the sequencer state encoding.
package fp_norm_round_pack_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  localparam int IDX_S  = 0;
  localparam int IDX_R  = 1;
  localparam int IDX_G  = 2;
  localparam int IDX_F0 = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SHIFT,
    ST_ROUND,
    ST_DONE
  } state_e;

  function automatic int idxH(input int manW);
    return manW + 3;
  endfunction

  function automatic int idxC(input int manW);
    return manW + 4;
  endfunction

endpackage

// File: rtl/fp_norm_round_pack_rne_round.sv
// Round-to-nearest-even on a normalized {H, F, G, R, S} significand.
// A wrap of {H,F} to zero (carry out) means the rounded value reached 2.0.
module rne_round
  import fp_norm_round_pack_pkg::*;
#(
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic [MAN_W+3:0] i_mant,
  output logic [MAN_W:0]   o_sig,
  output logic             o_carry,
  output logic             o_inexact
);

  logic             w_inc;
  logic [MAN_W+1:0] w_sum;

  assign w_inc     = i_mant[IDX_G] & (i_mant[IDX_R] | i_mant[IDX_S] | i_mant[IDX_F0]);
  assign w_sum     = {1'b0, i_mant[MAN_W+3:IDX_F0]} + {{(MAN_W+1){1'b0}}, w_inc};
  assign o_sig     = w_sum[MAN_W:0];
  assign o_carry   = w_sum[MAN_W+1];
  assign o_inexact = i_mant[IDX_G] | i_mant[IDX_R] | i_mant[IDX_S];

endmodule

// File: rtl/fp_norm_round_pack.sv
// FP adder back end: normalizes the raw sum (right on carry-out, left one bit per
// cycle after cancellation), rounds to nearest-even and packs an IEEE-754 word.
module fp_norm_round_pack
  import fp_norm_round_pack_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+4:0]       in_mant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_ovf,
  output logic                   out_unf,
  output logic                   out_inexact
);

  localparam int MW = MAN_W + 5;
  localparam int IH = idxH(MAN_W);
  localparam int IC = idxC(MAN_W);
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  state_e               r_state;
  logic                 r_sign;
  logic [EXP_W:0]       r_exp;
  logic [MW-1:0]        r_mant;
  logic                 r_inReady;
  logic                 r_outValid;
  logic [EXP_W+MAN_W:0] r_outData;
  logic                 r_ovf;
  logic                 r_unf;
  logic                 r_inexact;

  logic [MW-1:0]        w_mantRsh;
  logic [MW-1:0]        w_mantLsh;
  logic [EXP_W:0]       w_expInc;
  logic [EXP_W:0]       w_expDec;
  logic [MAN_W:0]       w_rndSig;
  logic                 w_rndCarry;
  logic                 w_rndInexact;
  logic [EXP_W:0]       w_rndExp;

  logic                 w_emit;
  logic [EXP_W+MAN_W:0] w_emitData;
  logic                 w_emitOvf;
  logic                 w_emitUnf;
  logic                 w_emitInexact;

  // Right shift folds the bits falling off R into the sticky; left shift keeps S sticky.
  assign w_mantRsh = {1'b0, r_mant[MW-1:2], r_mant[IDX_R] | r_mant[IDX_S]};
  assign w_mantLsh = {r_mant[MW-2:1], r_mant[IDX_S], r_mant[IDX_S]};
  assign w_expInc  = r_exp + EXP_ONE;
  assign w_expDec  = r_exp - EXP_ONE;

  rne_round #(
    .MAN_W (MAN_W)
  ) u_rne (
    .i_mant    (r_mant[IH:0]),
    .o_sig     (w_rndSig),
    .o_carry   (w_rndCarry),
    .o_inexact (w_rndInexact)
  );

  // A cleared hidden bit after rounding means the significand wrapped to 2.0.
  assign w_rndExp = w_rndSig[MAN_W] ? r_exp : w_expInc;

  always_comb begin
    w_emit        = 1'b0;
    w_emitData    = '0;
    w_emitOvf     = 1'b0;
    w_emitUnf     = 1'b0;
    w_emitInexact = 1'b0;
    case (r_state)
      ST_CHECK: begin
        if (r_exp == EXP_MAX) begin
          w_emit     = 1'b1;
          w_emitData = {r_sign, {EXP_W{1'b1}}, r_mant[IH-1:IDX_F0]};
        end else if (r_mant == '0) begin
          w_emit     = 1'b1;
          w_emitData = {r_sign, {(EXP_W+MAN_W){1'b0}}};
        end else if (r_exp == '0) begin
          w_emit     = 1'b1;
          w_emitData = {r_sign, {(EXP_W+MAN_W){1'b0}}};
          w_emitUnf  = 1'b1;
        end else if (r_mant[IC] && (w_expInc == EXP_MAX)) begin
          w_emit     = 1'b1;
          w_emitData = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_emitOvf  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_exp == EXP_ONE) begin
          w_emit     = 1'b1;
          w_emitData = {r_sign, {(EXP_W+MAN_W){1'b0}}};
          w_emitUnf  = 1'b1;
        end
      end
      ST_ROUND: begin
        w_emit        = 1'b1;
        w_emitInexact = w_rndInexact;
        if (w_rndCarry && (w_rndExp == EXP_MAX)) begin
          w_emitData = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_emitOvf  = 1'b1;
        end else begin
          w_emitData = {r_sign, w_rndExp[EXP_W-1:0], w_rndSig[MAN_W-1:0]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_mant     <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_inexact  <= 1'b0;
    end else if (w_emit) begin
      r_state    <= ST_DONE;
      r_outValid <= 1'b1;
      r_outData  <= w_emitData;
      r_ovf      <= w_emitOvf;
      r_unf      <= w_emitUnf;
      r_inexact  <= w_emitInexact;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign    <= in_sign;
            r_exp     <= {1'b0, in_exp};
            r_mant    <= in_mant;
            r_inReady <= 1'b0;
            r_state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_mant[IC]) begin
            r_mant  <= w_mantRsh;
            r_exp   <= w_expInc;
            r_state <= ST_ROUND;
          end else if (r_mant[IH]) begin
            r_state <= ST_ROUND;
          end else begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_mant <= w_mantLsh;
          r_exp  <= w_expDec;
          if (w_mantLsh[IH]) begin
            r_state <= ST_ROUND;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = r_inReady;
  assign out_valid   = r_outValid;
  assign out_data    = r_outData;
  assign out_ovf     = r_ovf;
  assign out_unf     = r_unf;
  assign out_inexact = r_inexact;

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Directed bench for fp_norm_round_pack: an integer-arithmetic reference model
// plus hand-computed expectations, checked by a per-cycle output monitor.
module tb_fp_norm_round_pack;

  typedef struct {
    logic [31:0] data;
    bit          ovf;
    bit          unf;
    bit          inex;
    int          lat;
  } res_t;

  typedef struct {
    res_t  r;
    int    acc;
    string tag;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inexact;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    nOut = 0;
  bit    latChecked = 0;
  bit    expectIdle = 0;
  string curTag = "none";
  item_t expQ[$];
  item_t cur;

  fp_norm_round_pack #(
    .EXP_W (8),
    .MAN_W (23)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mant     (in_mant),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [27:0] mk(input bit c, input bit h, input logic [22:0] f,
                                     input logic [2:0] grs);
    return {c, h, f, grs};
  endfunction

  // Value-level reference: significand as an integer with 3 extra low bits (G,R,S).
  function automatic res_t model(input bit s, input int e, input logic [27:0] m);
    res_t   r;
    longint sig;
    longint kept;
    longint rem;
    int     n;
    int     ee;
    r.data = 32'h0; r.ovf = 0; r.unf = 0; r.inex = 0; r.lat = 2;
    if (e == 255) begin
      r.data = {s, 8'hFF, m[25:3]};
      return r;
    end
    if (m == 28'h0) begin
      r.data = {s, 31'h0};
      return r;
    end
    if (e == 0) begin
      r.data = {s, 31'h0};
      r.unf  = 1;
      return r;
    end
    sig = longint'(m);
    ee  = e;
    n   = 0;
    if (sig >= (64'sd1 << 27)) begin
      sig = (sig / 2) | (sig % 2);
      ee  = ee + 1;
      if (ee == 255) begin
        r.data = {s, 8'hFF, 23'h0};
        r.ovf  = 1;
        return r;
      end
    end else begin
      while (sig < (64'sd1 << 26)) begin
        if (ee == 1) begin
          r.data = {s, 31'h0};
          r.unf  = 1;
          r.lat  = 3 + n;
          return r;
        end
        sig = sig * 2 + (sig % 2);
        ee  = ee - 1;
        n++;
      end
    end
    r.lat  = 3 + n;
    kept   = sig / 8;
    rem    = sig % 8;
    r.inex = (rem != 0);
    if (rem > 4 || (rem == 4 && (kept % 2) == 1)) kept = kept + 1;
    if (kept == (64'sd1 << 24)) begin
      kept = 64'sd1 << 23;
      ee   = ee + 1;
    end
    if (ee >= 255) begin
      r.data = {s, 8'hFF, 23'h0};
      r.ovf  = 1;
    end else begin
      r.data = {s, ee[7:0], kept[22:0]};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) begin
      item_t it;
      it.r   = model(in_sign, int'(in_exp), in_mant);
      it.acc = cyc;
      it.tag = curTag;
      expQ.push_back(it);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      latChecked = 0;
      expectIdle = 0;
    end else begin
      if (expectIdle) begin
        checkOutput("idle_after_hs", {62'h0, in_ready, out_valid}, 64'h2);
        expectIdle = 0;
      end
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", {63'h0, out_valid}, 64'h0);
        end else begin
          cur = expQ[0];
          if (!latChecked) begin
            checkOutput({cur.tag, "_latency"}, cyc - cur.acc + 1, cur.r.lat);
            latChecked = 1;
          end
          checkOutput({cur.tag, "_data"}, out_data, cur.r.data);
          checkOutput({cur.tag, "_flags"}, {out_ovf, out_unf, out_inexact},
                      {cur.r.ovf, cur.r.unf, cur.r.inex});
          checkOutput({cur.tag, "_in_ready"}, in_ready, 1'b0);
          if (out_ready) begin
            void'(expQ.pop_front());
            latChecked = 0;
            expectIdle = 1;
            nOut++;
          end
        end
      end
    end
  end

  // Drives one vector and pins the reference model to the hand-computed answer.
  task automatic applyStimulus(input string tag, input bit s, input logic [7:0] e,
                               input logic [27:0] m, input logic [31:0] litData,
                               input logic [2:0] litFlags, input int litLat);
    res_t p;
    int   t;
    p = model(s, int'(e), m);
    checkOutput({tag, "_pin_data"}, p.data, litData);
    checkOutput({tag, "_pin_flags"}, {p.ovf, p.unf, p.inex}, litFlags);
    checkOutput({tag, "_pin_lat"}, p.lat, litLat);
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checkOutput({tag, "_accept_timeout"}, {63'h0, in_ready}, 64'h1);
      return;
    end
    curTag   = tag;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int t;
    t = 0;
    while (expQ.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drain_timeout", expQ.size(), 0);
      expQ.delete();
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
    checkOutput({tag, "_out_valid"}, out_valid, 1'b0);
    checkOutput({tag, "_out_data"}, out_data, 32'h0);
    checkOutput({tag, "_flags"}, {out_ovf, out_unf, out_inexact}, 3'b000);
  endtask

  initial begin
    int t;
    int nBefore;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h0;
    in_mant   = 28'h0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkIdleOutputs("post_reset");

    applyStimulus("carry", 1'b0, 8'h7F, mk(1, 1, 23'h0, 3'b000), 32'h40400000, 3'b000, 3);
    waitDrain(100);
    applyStimulus("cancel", 1'b0, 8'h85, mk(0, 0, 23'h000001, 3'b000), 32'h37000000, 3'b000, 26);
    waitDrain(100);
    applyStimulus("rne_odd", 1'b0, 8'h7F, mk(0, 1, 23'h000001, 3'b100), 32'h3F800002, 3'b001, 3);
    waitDrain(100);
    applyStimulus("rne_even", 1'b0, 8'h7F, mk(0, 1, 23'h000002, 3'b100), 32'h3F800002, 3'b001, 3);
    waitDrain(100);
    applyStimulus("rnd_ovf", 1'b0, 8'hFE, mk(0, 1, 23'h7FFFFF, 3'b110), 32'h7F800000, 3'b101, 3);
    waitDrain(100);
    applyStimulus("special", 1'b1, 8'hFF, mk(0, 1, 23'h400000, 3'b000), 32'hFFC00000, 3'b000, 2);
    waitDrain(100);
    applyStimulus("exp0_flush", 1'b1, 8'h00, mk(0, 1, 23'h000005, 3'b000), 32'h80000000, 3'b010, 2);
    waitDrain(100);
    applyStimulus("chk_ovf", 1'b0, 8'hFE, mk(1, 0, 23'h0, 3'b000), 32'h7F800000, 3'b100, 2);
    waitDrain(100);
    applyStimulus("shift_flush", 1'b0, 8'h02, mk(0, 0, 23'h000001, 3'b000), 32'h00000000, 3'b010, 4);
    waitDrain(100);
    applyStimulus("tie_up", 1'b0, 8'h80, mk(0, 1, 23'h000003, 3'b100), 32'h40000004, 3'b001, 3);
    waitDrain(100);
    applyStimulus("below_half", 1'b0, 8'h80, mk(0, 1, 23'h000003, 3'b011), 32'h40000003, 3'b001, 3);
    waitDrain(100);
    applyStimulus("rnd_carry", 1'b0, 8'h7F, mk(0, 1, 23'h7FFFFF, 3'b101), 32'h40000000, 3'b001, 3);
    waitDrain(100);
    applyStimulus("shift_sticky", 1'b1, 8'h90, mk(0, 0, 23'h600000, 3'b001), 32'hC7C00000, 3'b001, 4);
    waitDrain(100);

    out_ready = 1'b0;
    applyStimulus("zero_bp", 1'b0, 8'h40, 28'h0, 32'h00000000, 3'b000, 2);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("zero_bp_valid_seen", out_valid, 1'b1);
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    waitDrain(100);

    applyStimulus("reset_mid", 1'b0, 8'h85, mk(0, 0, 23'h000001, 3'b000), 32'h37000000, 3'b000, 26);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkIdleOutputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkIdleOutputs("after_abort");
    nBefore = nOut;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_emit", nOut, nBefore);
    checkOutput("abort_still_idle", {in_ready, out_valid}, 2'b10);

    applyStimulus("recover", 1'b0, 8'h7F, mk(1, 1, 23'h0, 3'b000), 32'h40400000, 3'b000, 3);
    waitDrain(100);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
